cmem_fill: RTL and testbench
============================

# cmem_fill

Line-fill responder for the shared cache's external read bus. It receives a block-address read request from `cmem` and assembles a full cache line from a 64-bit backing-memory port in sequential beats. It returns the line with a single-cycle data-valid pulse. It also turns snooped writes from other bus masters into one-cycle cache invalidations on the `cmem` invalidation port. It sits between `cmem` and the memory interconnect.

## Interface
- `LINE_W`, 512: cache line width in bits; a power of two and at least 64.
- Derived: `BEATS = LINE_W/64`; `OFFS = log2(LINE_W/8)`; `BLK_LEN = 64 - OFFS`. With defaults: 8 beats, 6 offset bits, 58 block bits.

Ports, clock and reset first:
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `b_addr_c`  in  BLK_LEN  requested block address; stable while `b_rd_c` is high.
- `b_rd_c`  in  1  line read request; level, held until `b_dv_c`.
- `b_rdata_c`  out  LINE_W  assembled line; beat k sits in `[64k +: 64]`.
- `b_dv_c`  out  1  line valid; one-cycle pulse.
- `b_inv_addr_c`  out  BLK_LEN  block address to invalidate.
- `inv`  out  1  invalidate strobe; one-cycle pulse.
- `m_addr`  out  64  backing-memory byte address, 8-byte aligned.
- `m_rd`  out  1  beat read request; level.
- `m_rdata`  in  64  beat data.
- `m_dv`  in  1  beat valid; sampled only while `m_rd` is high.
- `s_addr`  in  64  snooped write byte address.
- `s_wr`  in  1  snooped write strobe; one cycle per write.

## Operation
- FSM states: IDLE, FETCH, DONE, HOLD.
- IDLE:
  - `b_rd_c` high at an edge latches `b_addr_c` into `blk`, clears `beat` to 0, and enters FETCH.
- FETCH:
  - `m_rd` = 1 and `m_addr` = `{blk, beat[log2 BEATS-1:0], 3'b000}`.
  - At each edge where `m_dv` is high, capture `m_rdata` into line slot `beat` and increment `beat`.
  - The capture of beat `BEATS-1` enters DONE.
- DONE: `b_dv_c` = 1 for exactly one cycle, then go to HOLD.
- HOLD: wait for `b_rd_c` low, then go to IDLE. A still-high `b_rd_c` must never start a second fill.
- Abort: if `b_rd_c` drops during FETCH, finish the outstanding beat (wait for `m_dv`), discard the line, go to IDLE, and never pulse `b_dv_c`.
- Snoop collision: `s_wr` during FETCH with `s_addr[63:OFFS] == blk` sets `restart`.
  - On the next beat capture, set `beat` to 0 and clear `restart`. The fill re-reads all beats; data from before the collision is never delivered.
  - A collision on the capture edge of the last beat also restarts; DONE is not entered.
- Invalidation: `s_wr` at edge t drives `inv` = 1 and `b_inv_addr_c = s_addr[63:OFFS]` in cycle t+1.
  - Independent of FSM state; back-to-back `s_wr` gives back-to-back `inv`.
  - `b_inv_addr_c` holds its last value while `inv` is low.
- `s_wr` during DONE or HOLD on `blk` does not affect the delivered line; the following `inv` cleans the cache.

## Timing
- Reset values of outputs:
  - 0: `b_rdata_c`, `b_dv_c`, `inv`, `b_inv_addr_c`, `m_rd`, `m_addr`.
  - FSM returns to IDLE; `restart` = 0.
- Reset mid-fill: next cycle `m_rd` = 0; in-flight `m_dv` is ignored.
- Request accepted at edge E0:
  - `m_rd` is high from cycle E0+1.
  - With a zero-wait memory (`m_dv` high whenever `m_rd` is high), beats are captured at edges E1..E8, `b_dv_c` is high in cycle E8+1, and the FSM is in HOLD from E9.
- `m_rd` stays high continuously across beats; `m_addr` advances the cycle after each capture.
- `b_rdata_c` updates per beat, is valid in the `b_dv_c` cycle, and holds until the next fill's first capture.
- `cmem` leaves its fetch state on `b_dv_c` and therefore drops `b_rd_c` in the HOLD cycle. Minimum IDLE-to-IDLE turnaround is `BEATS` + 3 cycles.

## Test plan
- Zero-wait fill:
  - Stimulus: `b_addr_c`=0x1234, memory returns word = byte address.
  - Response: `m_addr` steps 0x48D00..0x48D38; `b_dv_c` pulses once, 9 cycles after acceptance; slot k = 0x48D00+8k.
- Wait-state fill:
  - Stimulus: `m_dv` every 3rd cycle.
  - Response: same line data; `m_rd` never drops mid-fill; exactly one `b_dv_c`.
- Held request:
  - Stimulus: `b_rd_c` kept high 5 cycles after `b_dv_c`.
  - Response: no new `m_rd`; a fresh fill starts only after `b_rd_c` goes low then high.
- Snoop collision:
  - Stimulus: `s_wr`, `s_addr`=0x48D10 during beat 3.
  - Response: beat 4 request is replaced by beat 0 re-read; `inv` pulses with 0x1234; line delivered after a full 8-beat re-read.
- Non-colliding snoops:
  - Stimulus: `s_wr` on 0x1000 and 0x2000 in consecutive cycles during a fill.
  - Response: `inv` high two cycles, addresses 0x40 then 0x80; fill timing unchanged.
- Reset and abort:
  - Stimulus: `rst` at beat 5.
  - Response: `m_rd`/`b_dv_c` are 0 the next cycle and all outputs are 0.
  - Stimulus: `b_rd_c` dropped at beat 2.
  - Response: no `b_dv_c`; FSM returns to IDLE.

Source files
------------

// File: rtl/cmem_fill.sv
// Line-fill responder for the shared cache's external read bus.
// Assembles a full cache line from sequential 64-bit backing-memory beats,
// returns it to cmem with a one-cycle valid pulse, and turns snooped writes
// from other bus masters into one-cycle invalidations on the cmem port.
module cmem_fill #(
  parameter int unsigned  LINE_W  = 512,
  localparam int unsigned BEATS   = LINE_W / 64,
  localparam int unsigned OFFS    = $clog2(LINE_W / 8),
  localparam int unsigned BLK_LEN = 64 - OFFS
) (
  input  logic               clk,
  input  logic               rst,
  // cmem read request / line return
  input  logic [BLK_LEN-1:0] b_addr_c,
  input  logic               b_rd_c,
  output logic [LINE_W-1:0]  b_rdata_c,
  output logic               b_dv_c,
  // cmem invalidation port
  output logic [BLK_LEN-1:0] b_inv_addr_c,
  output logic               inv,
  // backing-memory beat port
  output logic [63:0]        m_addr,
  output logic               m_rd,
  input  logic [63:0]        m_rdata,
  input  logic               m_dv,
  // snooped writes from other masters
  input  logic [63:0]        s_addr,
  input  logic               s_wr
);

  // Beat counter needs at least one bit even for a single-beat line.
  localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BEAT_W-1:0] LastBeat = BEAT_W'(BEATS - 1);

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StDone,
    StHold
  } state_e;

  state_e             state_q, state_d;
  logic [BLK_LEN-1:0] blk_q, blk_d;
  logic [BEAT_W-1:0]  beat_q, beat_d;
  logic               restart_q, restart_d;
  logic               abort_q, abort_d;
  logic [LINE_W-1:0]  line_q;
  logic               line_we;
  logic               inv_q;
  logic [BLK_LEN-1:0] inv_addr_q;

  logic [BLK_LEN-1:0] snoop_blk;
  logic               snoop_hit;
  logic               last_beat;

  assign snoop_blk = s_addr[63:OFFS];
  // Only a write to the block being filled can stale the beats already captured.
  assign snoop_hit = s_wr && (snoop_blk == blk_q);
  assign last_beat = (beat_q == LastBeat);

  // Next-state, beat bookkeeping and handshake outputs.
  always_comb begin
    state_d   = state_q;
    blk_d     = blk_q;
    beat_d    = beat_q;
    restart_d = restart_q;
    abort_d   = abort_q;
    line_we   = 1'b0;
    m_rd      = 1'b0;
    b_dv_c    = 1'b0;

    case (state_q)
      StIdle: begin
        if (b_rd_c) begin
          blk_d     = b_addr_c;
          beat_d    = '0;
          restart_d = 1'b0;
          abort_d   = 1'b0;
          state_d   = StFetch;
        end
      end

      StFetch: begin
        m_rd = 1'b1;
        // The outstanding beat must still complete, so only remember the drop.
        if (!b_rd_c) begin
          abort_d = 1'b1;
        end
        if (m_dv) begin
          if (abort_q || !b_rd_c) begin
            // Requester gave up: drop the partial line, never signal valid.
            abort_d   = 1'b0;
            restart_d = 1'b0;
            state_d   = StIdle;
          end else begin
            line_we = 1'b1;
            if (restart_q || snoop_hit) begin
              // Data already captured may predate the snooped write: re-read all.
              beat_d    = '0;
              restart_d = 1'b0;
            end else if (last_beat) begin
              state_d = StDone;
            end else begin
              beat_d = beat_q + 1'b1;
            end
          end
        end else if (snoop_hit) begin
          restart_d = 1'b1;
        end
      end

      StDone: begin
        b_dv_c  = 1'b1;
        state_d = StHold;
      end

      StHold: begin
        // A request still held from the delivered fill must not start another.
        if (!b_rd_c) begin
          state_d = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Beat address is only driven while fetching so idle/reset reads as zero.
  always_comb begin
    m_addr = '0;
    if (state_q == StFetch) begin
      m_addr = {blk_q, {OFFS{1'b0}}} | (64'(beat_q) << 3);
    end
  end

  // FSM and fill-control state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      blk_q     <= '0;
      beat_q    <= '0;
      restart_q <= 1'b0;
      abort_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      blk_q     <= blk_d;
      beat_q    <= beat_d;
      restart_q <= restart_d;
      abort_q   <= abort_d;
    end
  end

  // Line assembly: each accepted beat lands in its slot; the line holds between fills.
  always_ff @(posedge clk) begin
    if (rst) begin
      line_q <= '0;
    end else if (line_we) begin
      line_q[beat_q*64 +: 64] <= m_rdata;
    end
  end

  // Snoop-driven invalidation, independent of the fill FSM.
  always_ff @(posedge clk) begin
    if (rst) begin
      inv_q      <= 1'b0;
      inv_addr_q <= '0;
    end else begin
      inv_q <= s_wr;
      if (s_wr) begin
        inv_addr_q <= snoop_blk;
      end
    end
  end

  assign b_rdata_c    = line_q;
  assign inv          = inv_q;
  assign b_inv_addr_c = inv_addr_q;

endmodule

// File: tb/tb_cmem_fill.sv
// Self-checking bench for cmem_fill: table of fill scenarios plus hand-written
// reset and abort sequences; beats, lines and invalidations go through queues.
module tb_cmem_fill;

  localparam int unsigned LINE_W  = 512;
  localparam int unsigned BEATS   = 8;
  localparam int unsigned OFFS    = 6;
  localparam int unsigned BLK_LEN = 58;

  logic               clk = 1'b0;
  logic               rst;
  logic [BLK_LEN-1:0] b_addr_c;
  logic               b_rd_c;
  logic [LINE_W-1:0]  b_rdata_c;
  logic               b_dv_c;
  logic [BLK_LEN-1:0] b_inv_addr_c;
  logic               inv;
  logic [63:0]        m_addr;
  logic               m_rd;
  logic [63:0]        m_rdata;
  logic               m_dv;
  logic [63:0]        s_addr;
  logic               s_wr;

  always #5 clk = ~clk;

  cmem_fill #(.LINE_W(LINE_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .b_addr_c     (b_addr_c),
    .b_rd_c       (b_rd_c),
    .b_rdata_c    (b_rdata_c),
    .b_dv_c       (b_dv_c),
    .b_inv_addr_c (b_inv_addr_c),
    .inv          (inv),
    .m_addr       (m_addr),
    .m_rd         (m_rd),
    .m_rdata      (m_rdata),
    .m_dv         (m_dv),
    .s_addr       (s_addr),
    .s_wr         (s_wr)
  );

  // Memory model: word = byte address; m_dv on every mem_period-th cycle of m_rd.
  int mem_period = 1;
  int wcnt = 0;
  assign m_rdata = m_addr;
  assign m_dv    = m_rd && (wcnt == mem_period - 1);
  always @(posedge clk) begin
    if (!m_rd || m_dv) wcnt <= 0;
    else               wcnt <= wcnt + 1;
  end

  // Monitor: records what the DUT produces; only appends.
  logic [63:0]        obs_beat[$];
  logic [LINE_W-1:0]  obs_line[$];
  logic [BLK_LEN-1:0] obs_inv[$];
  int   dv_cnt   = 0;
  int   mrd_fall = 0;
  logic mrd_prev = 1'b0;
  always @(negedge clk) begin
    if (m_rd && m_dv) obs_beat.push_back(m_addr);
    if (b_dv_c) begin
      obs_line.push_back(b_rdata_c);
      dv_cnt <= dv_cnt + 1;
    end
    if (inv) obs_inv.push_back(b_inv_addr_c);
    if (mrd_prev && !m_rd) mrd_fall <= mrd_fall + 1;
    mrd_prev <= m_rd;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [BLK_LEN-1:0] blk;
    int                 period;  // m_dv spacing in cycles
    int                 sn_at;   // cycle after acceptance to drive s_wr, -1 none
    logic [63:0]        sn_a0;
    logic [63:0]        sn_a1;
    int                 sn_n;    // number of back-to-back snoops
    int                 rs;      // last beat index captured before a restart, -1 none
    int                 lat;     // edges from acceptance to b_dv_c
    int                 hold;    // extra cycles b_rd_c stays high after b_dv_c
  } vec_t;

  vec_t vecs[7];
  logic [BLK_LEN-1:0] exp_line_q[$];

  task automatic do_fill(input vec_t v);
    int lat, held_mrd, beat_base, line_base, inv_base, dv_base, fall_base;
    bit done, sw;
    logic [63:0]        exp_beats[$];
    logic [BLK_LEN-1:0] exp_inv[$];
    logic [BLK_LEN-1:0] exp_blk;
    logic [LINE_W-1:0]  ln;
    logic [63:0]        base;

    beat_base = obs_beat.size();
    line_base = obs_line.size();
    inv_base  = obs_inv.size();
    dv_base   = dv_cnt;
    fall_base = mrd_fall;
    base      = 64'(v.blk) << OFFS;
    for (int k = 0; k <= v.rs; k++) exp_beats.push_back(base + 64'(8 * k));
    for (int k = 0; k < BEATS; k++) exp_beats.push_back(base + 64'(8 * k));

    mem_period = v.period;
    b_addr_c   = v.blk;
    b_rd_c     = 1'b1;
    exp_line_q.push_back(v.blk);
    @(posedge clk); #1;
    lat  = 0;
    done = 1'b0;
    while (!done && lat < 200) begin
      if (v.sn_at >= 0 && lat == v.sn_at) begin
        s_wr = 1'b1; s_addr = v.sn_a0; exp_inv.push_back(v.sn_a0[63:OFFS]);
      end else if (v.sn_n > 1 && lat == v.sn_at + 1) begin
        s_wr = 1'b1; s_addr = v.sn_a1; exp_inv.push_back(v.sn_a1[63:OFFS]);
      end else begin
        s_wr = 1'b0;
      end
      sw = s_wr;
      @(posedge clk); #1;
      lat++;
      if (sw) check("inv_timing", 64'(inv), 64'd1);
      if (b_dv_c) done = 1'b1;
    end
    s_wr = 1'b0;
    check("dv_latency", 64'(lat), 64'(v.lat));

    held_mrd = 0;
    repeat (v.hold + 1) begin
      @(posedge clk); #1;
      if (m_rd) held_mrd++;
    end
    b_rd_c = 1'b0;
    @(posedge clk); #1;
    check("held_no_mrd", 64'(held_mrd), 64'd0);
    check("dv_count", 64'(dv_cnt - dv_base), 64'd1);
    check("mrd_falls", 64'(mrd_fall - fall_base), 64'd1);

    check("beat_count", 64'(obs_beat.size() - beat_base), 64'(exp_beats.size()));
    for (int i = 0; i < exp_beats.size(); i++) begin
      if (beat_base + i < obs_beat.size())
        check("beat_addr", obs_beat[beat_base + i], exp_beats[i]);
    end

    exp_blk = exp_line_q.pop_front();
    if (obs_line.size() > line_base) begin
      ln = obs_line[line_base];
      for (int k = 0; k < BEATS; k++)
        check("line_slot", ln[k*64 +: 64], (64'(exp_blk) << OFFS) + 64'(8 * k));
    end else begin
      check("line_present", 64'd0, 64'd1);
    end

    check("inv_count", 64'(obs_inv.size() - inv_base), 64'(exp_inv.size()));
    for (int i = 0; i < exp_inv.size(); i++) begin
      if (inv_base + i < obs_inv.size())
        check("inv_addr", 64'(obs_inv[inv_base + i]), 64'(exp_inv[i]));
    end
  endtask

  initial begin
    int cnt, dv_base, beat_base;

    //           blk       per sn_at sn_a0       sn_a1     n  rs  lat hold
    vecs[0] = '{58'h1234,  1,  -1,  64'h0,      64'h0,    0, -1,  8, 0};
    vecs[1] = '{58'h1234,  3,  -1,  64'h0,      64'h0,    0, -1, 24, 0};
    vecs[2] = '{58'h2A5,   1,  -1,  64'h0,      64'h0,    0, -1,  8, 5};
    vecs[3] = '{58'h1234,  1,   3,  64'h48D10,  64'h0,    1,  3, 12, 0};
    vecs[4] = '{58'h1234,  1,   2,  64'h1000,   64'h2000, 2, -1,  8, 0};
    vecs[5] = '{'1,        2,  -1,  64'h0,      64'h0,    0, -1, 16, 0};
    vecs[6] = '{58'h1234,  3,   4,  64'h48D3F,  64'h0,    1,  1, 30, 0};

    rst = 1'b1; b_addr_c = '0; b_rd_c = 1'b0; s_addr = '0; s_wr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_rdata", 64'(b_rdata_c != '0), 64'd0);
    check("rst_dv", 64'(b_dv_c), 64'd0);
    check("rst_inv", 64'(inv), 64'd0);
    check("rst_inv_addr", 64'(b_inv_addr_c), 64'd0);
    check("rst_mrd", 64'(m_rd), 64'd0);
    check("rst_maddr", m_addr, 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 7; i++) do_fill(vecs[i]);

    // Reset during beat 5 of a zero-wait fill, with a coincident snoop.
    mem_period = 1;
    b_addr_c = 58'h1234; b_rd_c = 1'b1;
    @(posedge clk); #1;
    repeat (5) begin @(posedge clk); #1; end
    rst = 1'b1; s_wr = 1'b1; s_addr = 64'h5000;
    @(posedge clk); #1;
    check("midrst_mrd", 64'(m_rd), 64'd0);
    check("midrst_dv", 64'(b_dv_c), 64'd0);
    check("midrst_rdata", 64'(b_rdata_c != '0), 64'd0);
    check("midrst_inv", 64'(inv), 64'd0);
    check("midrst_inv_addr", 64'(b_inv_addr_c), 64'd0);
    check("midrst_maddr", m_addr, 64'd0);
    rst = 1'b0; s_wr = 1'b0; b_rd_c = 1'b0;
    @(posedge clk); #1;
    check("postrst_mrd", 64'(m_rd), 64'd0);

    // Abort: request dropped while beat 2 is outstanding with wait states.
    mem_period = 3;
    dv_base    = dv_cnt;
    beat_base  = obs_beat.size();
    b_addr_c = 58'h77; b_rd_c = 1'b1;
    @(posedge clk); #1;
    repeat (7) begin @(posedge clk); #1; end
    b_rd_c = 1'b0;
    @(posedge clk); #1;
    check("abort_mrd_outstanding", 64'(m_rd), 64'd1);
    @(posedge clk); #1;
    check("abort_mrd_off", 64'(m_rd), 64'd0);
    cnt = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (m_rd || b_dv_c) cnt++;
    end
    check("abort_quiet", 64'(cnt), 64'd0);
    check("abort_no_dv", 64'(dv_cnt - dv_base), 64'd0);
    check("abort_beats", 64'(obs_beat.size() - beat_base), 64'd3);

    // Recovery: a normal fill after reset and abort.
    do_fill(vecs[0]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
